// File: rtl/usb_xact_engine.sv
// USB host transaction engine: token, optional data, handshake, retry/timeout.
// Optional per-endpoint data toggling is enabled with USB_XACT_TOGGLE_EN.
`timescale 1ns/1ps
module usb_xact_engine #(
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 256,
  parameter int MAX_RETRY   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_dir,
  input  logic [6:0]        req_addr,
  input  logic [3:0]        req_endp,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [1:0]        rsp_status,
  output logic [DATA_W-1:0] rsp_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [3:0]        tx_pid,
  output logic [6:0]        tx_addr,
  output logic [3:0]        tx_endp,
  output logic              tx_has_data,
  output logic [DATA_W-1:0] tx_data,
  input  logic              rx_valid,
  input  logic [3:0]        rx_pid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_crc_err,
  input  logic              rx_busy
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  typedef enum logic [2:0] {
    S_IDLE, S_TOKEN, S_DATA_TX, S_WAIT_HS,
    S_WAIT_DATA, S_SEND_ACK, S_DONE, S_FAIL
  } state_t;

  state_t            state_q;
  logic              dir_q;
  logic [6:0]        addr_q;
  logic [3:0]        endp_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rxd_q;
  logic [3:0]        retry_q;
  logic [3:0]        retry_d;
  logic [TW-1:0]     timer_q;
  logic              disc_q;

`ifdef USB_XACT_TOGGLE_EN
  logic [15:0]       tog_q;
`endif

  logic       xfer;
  logic       tmo;
  logic       wait_st;
  logic       retry_ev;
  logic       retry_max;
  logic       is_data;
  logic       tog_ok;
  logic [3:0] tok_pid;
  logic [3:0] dpid;

  always_comb begin
    xfer    = tx_valid & tx_ready;
    tok_pid = dir_q ? PID_IN : PID_OUT;
`ifdef USB_XACT_TOGGLE_EN
    dpid    = tog_q[endp_q] ? PID_DATA1 : PID_DATA0;
    tog_ok  = (rx_pid == dpid);
`else
    dpid    = PID_DATA0;
    tog_ok  = 1'b1;
`endif
    is_data   = (rx_pid == PID_DATA0) || (rx_pid == PID_DATA1);
    wait_st   = (state_q == S_WAIT_HS) || (state_q == S_WAIT_DATA);
    tmo       = !rx_valid && !rx_busy
                && (timer_q == TW'(TIMEOUT_CYC - 1));
    retry_ev  = wait_st
                && ((rx_valid && (rx_crc_err || rx_pid == PID_NAK)) || tmo);
    retry_d   = retry_q + 4'd1;
    retry_max = (retry_d == 4'(MAX_RETRY));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_status  <= 2'b00;
      rsp_data    <= '0;
      tx_valid    <= 1'b0;
      tx_pid      <= 4'd0;
      tx_addr     <= 7'd0;
      tx_endp     <= 4'd0;
      tx_has_data <= 1'b0;
      tx_data     <= '0;
      dir_q       <= 1'b0;
      addr_q      <= 7'd0;
      endp_q      <= 4'd0;
      data_q      <= '0;
      rxd_q       <= '0;
      retry_q     <= 4'd0;
      timer_q     <= '0;
      disc_q      <= 1'b0;
`ifdef USB_XACT_TOGGLE_EN
      tog_q       <= 16'd0;
`endif
    end else if (retry_ev) begin
      retry_q <= retry_d;
      timer_q <= '0;
      if (retry_max) begin
        state_q    <= S_FAIL;
        rsp_valid  <= 1'b1;
        rsp_status <= 2'b01;
        rsp_data   <= '0;
      end else begin
        state_q     <= S_TOKEN;
        tx_valid    <= 1'b1;
        tx_pid      <= tok_pid;
        tx_addr     <= addr_q;
        tx_endp     <= endp_q;
        tx_has_data <= 1'b0;
        tx_data     <= '0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            req_ready   <= 1'b0;
            dir_q       <= req_dir;
            addr_q      <= req_addr;
            endp_q      <= req_endp;
            data_q      <= req_data;
            rxd_q       <= '0;
            retry_q     <= 4'd0;
            timer_q     <= '0;
            disc_q      <= 1'b0;
            state_q     <= S_TOKEN;
            tx_valid    <= 1'b1;
            tx_pid      <= req_dir ? PID_IN : PID_OUT;
            tx_addr     <= req_addr;
            tx_endp     <= req_endp;
            tx_has_data <= 1'b0;
            tx_data     <= '0;
          end
        end
        S_TOKEN: begin
          if (xfer) begin
            timer_q <= '0;
            if (!dir_q) begin
              state_q     <= S_DATA_TX;
              tx_pid      <= dpid;
              tx_has_data <= 1'b1;
              tx_data     <= data_q;
            end else begin
              state_q  <= S_WAIT_DATA;
              tx_valid <= 1'b0;
            end
          end
        end
        S_DATA_TX: begin
          if (xfer) begin
            state_q     <= S_WAIT_HS;
            tx_valid    <= 1'b0;
            tx_has_data <= 1'b0;
            timer_q     <= '0;
          end
        end
        S_WAIT_HS: begin
          if (rx_valid && !rx_crc_err && rx_pid == PID_ACK) begin
`ifdef USB_XACT_TOGGLE_EN
            tog_q[endp_q] <= ~tog_q[endp_q];
`endif
            state_q    <= S_DONE;
            rsp_valid  <= 1'b1;
            rsp_status <= 2'b00;
            rsp_data   <= '0;
          end else if (!rx_valid && !rx_busy) begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_WAIT_DATA: begin
          if (rx_valid && !rx_crc_err && is_data) begin
            // A stale toggle is still ACKed so the device advances.
            if (tog_ok) begin
              rxd_q  <= rx_data;
              disc_q <= 1'b0;
`ifdef USB_XACT_TOGGLE_EN
              tog_q[endp_q] <= ~tog_q[endp_q];
`endif
            end else begin
              disc_q <= 1'b1;
            end
            state_q     <= S_SEND_ACK;
            tx_valid    <= 1'b1;
            tx_pid      <= PID_ACK;
            tx_has_data <= 1'b0;
            tx_data     <= '0;
          end else if (!rx_valid && !rx_busy) begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_SEND_ACK: begin
          if (xfer) begin
            if (disc_q) begin
              disc_q   <= 1'b0;
              timer_q  <= '0;
              state_q  <= S_TOKEN;
              tx_pid   <= tok_pid;
              tx_addr  <= addr_q;
              tx_endp  <= endp_q;
            end else begin
              tx_valid   <= 1'b0;
              state_q    <= S_DONE;
              rsp_valid  <= 1'b1;
              rsp_status <= 2'b00;
              rsp_data   <= rxd_q;
            end
          end
        end
        S_DONE, S_FAIL: begin
          rsp_valid  <= 1'b0;
          rsp_status <= 2'b00;
          rsp_data   <= '0;
          req_ready  <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_xact_engine.sv
// Directed bench for usb_xact_engine with an expected-packet model.
// Toggle expectations follow USB_XACT_TOGGLE_EN when it is defined.
`timescale 1ns/1ps
module tb_usb_xact_engine;

  localparam logic [3:0] P_OUT = 4'b0001;
  localparam logic [3:0] P_IN  = 4'b1001;
  localparam logic [3:0] P_D0  = 4'b0011;
  localparam logic [3:0] P_D1  = 4'b1011;
  localparam logic [3:0] P_ACK = 4'b0010;
  localparam logic [3:0] P_NAK = 4'b1010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_dir = 1'b0;
  logic [6:0]  req_addr = '0;
  logic [3:0]  req_endp = '0;
  logic [63:0] req_data = '0;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic [63:0] rsp_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [3:0]  tx_pid;
  logic [6:0]  tx_addr;
  logic [3:0]  tx_endp;
  logic        tx_has_data;
  logic [63:0] tx_data;
  logic        rx_valid = 1'b0;
  logic [3:0]  rx_pid = '0;
  logic [63:0] rx_data = '0;
  logic        rx_crc_err = 1'b0;
  logic        rx_busy = 1'b0;

  usb_xact_engine dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
    .req_addr(req_addr), .req_endp(req_endp), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_data(rsp_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_pid(tx_pid),
    .tx_addr(tx_addr), .tx_endp(tx_endp), .tx_has_data(tx_has_data),
    .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_pid(rx_pid), .rx_data(rx_data),
    .rx_crc_err(rx_crc_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic        hd;
    logic [63:0] data;
  } pkt_t;

  typedef struct {
    logic [1:0]  st;
    logic [63:0] d;
  } rsp_t;

  pkt_t exp_tx[$];
  rsp_t exp_rsp[$];
  logic tog[16];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: data PID the host must use / expect on an endpoint.
  function automatic logic [3:0] dpid(input int e);
`ifdef USB_XACT_TOGGLE_EN
    return tog[e] ? P_D1 : P_D0;
`else
    return P_D0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) tog[i] = 1'b0;
  endtask

  task automatic push_tok(input logic d, input logic [6:0] a,
                          input logic [3:0] e);
    pkt_t p;
    p.pid = d ? P_IN : P_OUT; p.addr = a; p.endp = e;
    p.hd = 1'b0; p.data = '0;
    exp_tx.push_back(p);
  endtask

  task automatic push_dat(input logic [3:0] pid, input logic [63:0] x);
    pkt_t p;
    p.pid = pid; p.addr = '0; p.endp = '0; p.hd = 1'b1; p.data = x;
    exp_tx.push_back(p);
  endtask

  task automatic push_ack();
    pkt_t p;
    p.pid = P_ACK; p.addr = '0; p.endp = '0; p.hd = 1'b0; p.data = '0;
    exp_tx.push_back(p);
  endtask

  task automatic push_rsp(input logic [1:0] st, input logic [63:0] d);
    rsp_t r;
    r.st = st; r.d = d;
    exp_rsp.push_back(r);
  endtask

  pkt_t hold;
  logic stall = 1'b0;

  // Compare process: every transferred packet and response pulse.
  always @(negedge clk) begin
    pkt_t e;
    rsp_t r;
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("tx_hold_valid", 64'(tx_valid), 64'd1);
        chk("tx_hold_pid", 64'(tx_pid), 64'(hold.pid));
        chk("tx_hold_addr", 64'(tx_addr), 64'(hold.addr));
        chk("tx_hold_endp", 64'(tx_endp), 64'(hold.endp));
        chk("tx_hold_data", tx_data, hold.data);
      end
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL tx_unexpected: got pid %0h expected none", tx_pid);
        end else begin
          e = exp_tx.pop_front();
          chk("tx_pid", 64'(tx_pid), 64'(e.pid));
          chk("tx_has_data", 64'(tx_has_data), 64'(e.hd));
          if (e.pid == P_OUT || e.pid == P_IN) begin
            chk("tx_addr", 64'(tx_addr), 64'(e.addr));
            chk("tx_endp", 64'(tx_endp), 64'(e.endp));
          end
          if (e.hd) chk("tx_data", tx_data, e.data);
        end
      end
      stall = tx_valid && !tx_ready;
      hold.pid = tx_pid; hold.addr = tx_addr;
      hold.endp = tx_endp; hold.data = tx_data;
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rsp_unexpected: got status %0h expected none",
                   rsp_status);
        end else begin
          r = exp_rsp.pop_front();
          chk("rsp_status", 64'(rsp_status), 64'(r.st));
          chk("rsp_data", rsp_data, r.d);
        end
      end
    end
  end

  task automatic wait_xfer(input int lim, output int at);
    at = -1;
    for (int n = 0; n < lim; n++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL xfer_timeout: got none expected transfer");
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp(input int lim, output int at);
    at = -1;
    for (int n = 0; n < lim; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL rsp_timeout: got none expected rsp_valid");
    end
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic d, input logic [6:0] a,
                       input logic [3:0] e, input logic [63:0] x,
                       output int at);
    req_valid = 1'b1; req_dir = d; req_addr = a;
    req_endp = e; req_data = x;
    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    at = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic rx_pulse(input logic [3:0] pid, input logic [63:0] d,
                          input logic crc);
    rx_valid = 1'b1; rx_pid = pid; rx_data = d; rx_crc_err = crc;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_crc_err = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got hang expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, t, d, r, tk;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_status", 64'(rsp_status), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_tx_pid", 64'(tx_pid), 64'd0);
    chk("rst_tx_addr", 64'(tx_addr), 64'd0);
    chk("rst_tx_endp", 64'(tx_endp), 64'd0);
    chk("rst_tx_has_data", 64'(tx_has_data), 64'd0);
    chk("rst_tx_data", tx_data, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // OUT with immediate ACK: response in the 4th cycle after acceptance
    push_tok(0, 7'h10, 4'd5);
    push_dat(dpid(5), 64'h55);
    push_rsp(2'b00, 64'd0);
    issue(0, 7'h10, 4'd5, 64'h55, acc);
    wait_xfer(20, t);
    wait_xfer(20, t);
    rx_pulse(P_ACK, '0, 0);
    tog[5] = ~tog[5];
    wait_rsp(20, r);
    chk("out_latency", 64'(r - acc), 64'd4);

    // OUT addr 7 endp 3, ACK five cycles after the data packet
    push_tok(0, 7'h07, 4'd3);
    push_dat(P_D0, 64'haabbccdd);
    push_rsp(2'b00, 64'd0);
    issue(0, 7'h07, 4'd3, 64'haabbccdd, acc);
    wait_xfer(20, t);
    wait_xfer(20, t);
    idle(5);
    rx_pulse(P_ACK, '0, 0);
    tog[3] = ~tog[3];
    wait_rsp(20, r);

    // Stalled tx_ready, ignored PID, NAK retry, then ACK
    tx_ready = 1'b0;
    push_tok(0, 7'h22, 4'd7);
    push_dat(dpid(7), 64'h0123456789abcdef);
    push_tok(0, 7'h22, 4'd7);
    push_dat(dpid(7), 64'h0123456789abcdef);
    push_rsp(2'b00, 64'd0);
    issue(0, 7'h22, 4'd7, 64'h0123456789abcdef, acc);
    idle(4);
    tx_ready = 1'b1;
    wait_xfer(20, t);
    wait_xfer(20, t);
    rx_pulse(P_D1, 64'hffff, 0);
    rx_pulse(P_NAK, '0, 0);
    wait_xfer(20, t);
    wait_xfer(20, t);
    rx_pulse(P_ACK, '0, 0);
    tog[7] = ~tog[7];
    wait_rsp(20, r);

    // IN addr 5 endp 1, device returns DATA0 0x1234
    push_tok(1, 7'h05, 4'd1);
    push_ack();
    push_rsp(2'b00, 64'h1234);
    issue(1, 7'h05, 4'd1, 64'd0, acc);
    wait_xfer(20, t);
    idle(2);
    rx_pulse(P_D0, 64'h1234, 0);
    tog[1] = ~tog[1];
    wait_xfer(20, t);
    wait_rsp(20, r);

    // IN with two CRC errors then a good packet
    push_tok(1, 7'h33, 4'd6);
    push_tok(1, 7'h33, 4'd6);
    push_tok(1, 7'h33, 4'd6);
    push_ack();
    push_rsp(2'b00, 64'hdeadbeef01);
    issue(1, 7'h33, 4'd6, 64'd0, acc);
    for (int i = 0; i < 2; i++) begin
      wait_xfer(20, t);
      rx_pulse(dpid(6), 64'hbad, 1);
    end
    wait_xfer(20, t);
    rx_pulse(dpid(6), 64'hdeadbeef01, 0);
    tog[6] = ~tog[6];
    wait_xfer(20, t);
    wait_rsp(20, r);

    // No response at all: 8 timeouts then cancel; first wait has rx_busy
    for (int i = 0; i < 8; i++) begin
      push_tok(0, 7'h11, 4'd9);
      push_dat(dpid(9), 64'h99);
    end
    push_rsp(2'b01, 64'd0);
    issue(0, 7'h11, 4'd9, 64'h99, acc);
    d = 0;
    for (int i = 0; i < 8; i++) begin
      wait_xfer(600, tk);
      if (i == 1) chk("timeout_busy_gap", 64'(tk - d), 64'd267);
      if (i == 2) chk("timeout_gap", 64'(tk - d), 64'd257);
      wait_xfer(20, d);
      if (i == 0) begin
        idle(3);
        rx_busy = 1'b1;
        idle(10);
        rx_busy = 1'b0;
      end
    end
    wait_rsp(600, r);
    chk("cancel_latency", 64'(r - d), 64'd257);

    // Reset while a token is stalled: tx_valid drops at once
    tx_ready = 1'b0;
    issue(0, 7'h01, 4'd1, 64'h1, acc);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_async_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    idle(2);

    // Reset while waiting for the handshake: no response pulse
    push_tok(0, 7'h02, 4'd2);
    push_dat(dpid(2), 64'h2);
    issue(0, 7'h02, 4'd2, 64'h2, acc);
    wait_xfer(20, t);
    wait_xfer(20, t);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_wait_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_wait_rsp_valid", 64'(rsp_valid), 64'd0);
    idle(2);
    rst = 1'b0;
    model_reset();
    idle(5);

    // Fresh request after reset: 7 NAKs then ACK still succeeds
    for (int i = 0; i < 8; i++) begin
      push_tok(0, 7'h44, 4'd2);
      push_dat(dpid(2), 64'h4444);
    end
    push_rsp(2'b00, 64'd0);
    issue(0, 7'h44, 4'd2, 64'h4444, acc);
    for (int i = 0; i < 8; i++) begin
      wait_xfer(20, t);
      wait_xfer(20, t);
      rx_pulse(i < 7 ? P_NAK : P_ACK, '0, 0);
    end
    tog[2] = ~tog[2];
    wait_rsp(20, r);

    // Two OUTs to endp 12, then an IN on endp 13 answered with DATA1
    for (int k = 0; k < 2; k++) begin
      push_tok(0, 7'h0c, 4'd12);
`ifdef USB_XACT_TOGGLE_EN
      push_dat(k == 0 ? P_D0 : P_D1, 64'(k));
`else
      push_dat(P_D0, 64'(k));
`endif
      push_rsp(2'b00, 64'd0);
      issue(0, 7'h0c, 4'd12, 64'(k), acc);
      wait_xfer(20, t);
      wait_xfer(20, t);
      rx_pulse(P_ACK, '0, 0);
      tog[12] = ~tog[12];
      wait_rsp(20, r);
    end
    push_tok(1, 7'h0d, 4'd13);
    push_ack();
`ifdef USB_XACT_TOGGLE_EN
    push_tok(1, 7'h0d, 4'd13);
    push_ack();
    push_rsp(2'b00, 64'hc0de);
    issue(1, 7'h0d, 4'd13, 64'd0, acc);
    wait_xfer(20, t);
    rx_pulse(P_D1, 64'hdead, 0);
    wait_xfer(20, t);
    wait_xfer(20, t);
    rx_pulse(P_D0, 64'hc0de, 0);
    tog[13] = ~tog[13];
`else
    push_rsp(2'b00, 64'hc0de);
    issue(1, 7'h0d, 4'd13, 64'd0, acc);
    wait_xfer(20, t);
    rx_pulse(P_D1, 64'hc0de, 0);
`endif
    wait_xfer(20, t);
    wait_rsp(20, r);

    idle(3);
    chk("exp_tx_drained", 64'(exp_tx.size()), 64'd0);
    chk("exp_rsp_drained", 64'(exp_rsp.size()), 64'd0);
    chk("final_req_ready", 64'(req_ready), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
